// File: rtl/ysyx_23060075_ifu_prefetch_if.sv
// ---------------------------------------------------------------------------
// ysyx_23060075_ifu_prefetch_if
// Bundles the IFU prefetch signals: the redirect input, the decoupled
// request/response instruction-memory port and the instruction stream
// handed to the IDU.
//   master : the fetch unit (drives requests and the instruction stream)
//   slave  : environment side (memory, IDU, redirect source)
// ---------------------------------------------------------------------------
interface ysyx_23060075_ifu_prefetch_if #(
    parameter int ISA_WIDTH = 32
);
    logic                 redirect_valid;
    logic [ISA_WIDTH-1:0] redirect_pc;

    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic [ISA_WIDTH-1:0] mem_req_addr;
    logic                 mem_rsp_valid;
    logic [ISA_WIDTH-1:0] mem_rsp_data;
    logic                 mem_rsp_err;

    logic                 inst_valid;
    logic                 inst_ready;
    logic [ISA_WIDTH-1:0] inst;
    logic [ISA_WIDTH-1:0] inst_pc;
    logic [ISA_WIDTH-1:0] inst_snpc;
    logic                 inst_fault;

    modport master (
        input  redirect_valid, redirect_pc,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
        input  inst_ready,
        output mem_req_valid, mem_req_addr,
        output inst_valid, inst, inst_pc, inst_snpc, inst_fault
    );

    modport slave (
        output redirect_valid, redirect_pc,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
        output inst_ready,
        input  mem_req_valid, mem_req_addr,
        input  inst_valid, inst, inst_pc, inst_snpc, inst_fault
    );
endinterface

// File: rtl/ysyx_23060075_ifu_prefetch.sv
// ---------------------------------------------------------------------------
// ysyx_23060075_ifu_prefetch
// Instruction fetch unit with one outstanding memory request, an in-order
// prefetch FIFO of {pc, inst, fault} entries and redirect/flush handling.
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset
//   bus  - master modport: redirect in, memory req/rsp, instruction stream out
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | may issue a request at fpc when the FIFO has room
// WAIT  | request accepted, waiting for its response (will be pushed)
// DROP  | request accepted before a redirect, its response is discarded
// HALT  | access fault fetched; no requests until a redirect
// ---------------------------------------------------------------------------
module ysyx_23060075_ifu_prefetch #(
    parameter int                   ISA_WIDTH  = 32,
    parameter logic [ISA_WIDTH-1:0] RESET_PC   = ISA_WIDTH'(32'h8000_0000),
    parameter int                   FIFO_DEPTH = 4
) (
    input logic                               clk,
    input logic                               rst,
    ysyx_23060075_ifu_prefetch_if.master      bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP, S_HALT} state_t;

    state_t               state_q, state_d;
    logic [ISA_WIDTH-1:0] fpc_q;
    logic [ISA_WIDTH-1:0] req_pc_q;
    logic [PTR_W-1:0]     rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]     count_q;

    logic [ISA_WIDTH-1:0] pc_mem    [FIFO_DEPTH];
    logic [ISA_WIDTH-1:0] inst_mem  [FIFO_DEPTH];
    logic                 fault_mem [FIFO_DEPTH];

    logic req_valid, req_fire, push, pop;

    // The space check only happens in IDLE, so the slot of the in-flight
    // request is always reserved and WAIT can push unconditionally.
    always_comb begin
        state_d   = state_q;
        req_valid = 1'b0;
        push      = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_valid = !rst && (count_q < CNT_W'(FIFO_DEPTH));
                if (req_valid && bus.mem_req_ready)
                    state_d = bus.redirect_valid ? S_DROP : S_WAIT;
            end
            S_WAIT: begin
                if (bus.mem_rsp_valid) begin
                    if (bus.redirect_valid) begin
                        state_d = S_IDLE;
                    end else begin
                        push    = 1'b1;
                        state_d = bus.mem_rsp_err ? S_HALT : S_IDLE;
                    end
                end else if (bus.redirect_valid) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (bus.mem_rsp_valid)
                    state_d = S_IDLE;
            end
            S_HALT: begin
                if (bus.redirect_valid)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_fire          = req_valid & bus.mem_req_ready;
    assign bus.mem_req_valid = req_valid;
    assign bus.mem_req_addr  = fpc_q;

    assign bus.inst_valid = !rst && (count_q != '0);
    assign pop            = bus.inst_valid & bus.inst_ready & ~bus.redirect_valid;

    assign bus.inst       = inst_mem[rd_ptr_q];
    assign bus.inst_pc    = pc_mem[rd_ptr_q];
    assign bus.inst_snpc  = pc_mem[rd_ptr_q] + ISA_WIDTH'(4);
    assign bus.inst_fault = fault_mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            fpc_q    <= RESET_PC;
            req_pc_q <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            if (bus.redirect_valid)
                fpc_q <= bus.redirect_pc & ~ISA_WIDTH'(3);
            else if (req_fire)
                fpc_q <= fpc_q + ISA_WIDTH'(4);
            if (req_fire)
                req_pc_q <= fpc_q;
            if (bus.redirect_valid) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push)
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Fault entries store a zero instruction so the IDU never sees stale data.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= req_pc_q;
            inst_mem[wr_ptr_q]  <= bus.mem_rsp_err ? '0 : bus.mem_rsp_data;
            fault_mem[wr_ptr_q] <= bus.mem_rsp_err;
        end
    end
endmodule

// File: tb/tb_ysyx_23060075_ifu_prefetch.sv
module tb_ysyx_23060075_ifu_prefetch;
    localparam int          W   = 32;
    localparam int          D   = 4;
    localparam logic [31:0] RPC = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_23060075_ifu_prefetch_if #(.ISA_WIDTH(W)) bus ();

    ysyx_23060075_ifu_prefetch #(
        .ISA_WIDTH(W), .RESET_PC(RPC), .FIFO_DEPTH(D)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // stimulus knobs
    int rdy_mode, ird_mode, lat_min, lat_max, err_mode, redir_pct;
    logic [31:0] fault_addr;
    bit          redir_req;
    logic [31:0] redir_tgt;

    // reference model: memory with one outstanding access + stream expectations
    bit          pending, pend_stale, halted;
    logic [31:0] pend_addr;
    int          pend_wait;
    int          queued;
    logic [31:0] exp_req_addr, exp_pop_pc;

    // logs for directed checks
    int          hs_count, first_valid_cyc;
    logic [31:0] hs_addr_q[$];
    int          hs_cyc_q[$];
    logic [31:0] pop_pc_q[$], pop_snpc_q[$], pop_inst_q[$];
    logic        pop_fault_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    function automatic logic err_of(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word(a);
        if (err_mode == 1) return a == fault_addr;
        if (err_mode == 2) return w[7:4] == 4'h0;
        return 1'b0;
    endfunction

    task automatic clear_logs();
        hs_count = 0;
        first_valid_cyc = -1;
        hs_addr_q.delete(); hs_cyc_q.delete();
        pop_pc_q.delete(); pop_snpc_q.delete(); pop_inst_q.delete(); pop_fault_q.delete();
    endtask

    // One clock cycle: check outputs against the model, drive inputs, advance.
    task automatic cycle();
        bit exp_rv, hs, rsp, pop, redir, ird, rdy, exp_f;
        logic [31:0] exp_i;
        exp_rv = !pending && !halted && (queued < D);
        checks++;
        if (bus.mem_req_valid !== exp_rv) begin
            failures++;
            $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, bus.mem_req_valid, exp_rv);
        end
        checks++;
        if (bus.inst_valid !== (queued != 0)) begin
            failures++;
            $display("FAIL inst_valid cyc=%0d got=%b exp=%b", cyc, bus.inst_valid, queued != 0);
        end
        if (queued != 0) begin
            exp_f = err_of(exp_pop_pc);
            exp_i = exp_f ? 32'd0 : mem_word(exp_pop_pc);
            checks++;
            if (bus.inst_pc !== exp_pop_pc || bus.inst_snpc !== exp_pop_pc + 32'd4 ||
                bus.inst_fault !== exp_f || bus.inst !== exp_i) begin
                failures++;
                $display("FAIL head cyc=%0d got pc=%h snpc=%h inst=%h f=%b exp pc=%h snpc=%h inst=%h f=%b",
                         cyc, bus.inst_pc, bus.inst_snpc, bus.inst, bus.inst_fault,
                         exp_pop_pc, exp_pop_pc + 32'd4, exp_i, exp_f);
            end
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end

        rdy = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(1, 0) == 1);
        ird = (ird_mode == 1) || (ird_mode == 2 && $urandom_range(1, 0) == 1);
        redir = redir_req;
        if (!redir && redir_pct > 0 && $urandom_range(99, 0) < redir_pct + (halted ? 30 : 0)) begin
            redir = 1'b1;
            if ($urandom_range(3, 0) == 0) redir_tgt = 32'hFFFF_FFE0 | ($urandom & 32'h1F);
            else                           redir_tgt = $urandom;
        end
        rsp = pending && (pend_wait == 0);
        bus.mem_req_ready  = rdy;
        bus.inst_ready     = ird;
        bus.redirect_valid = redir;
        bus.redirect_pc    = redir ? redir_tgt : $urandom;
        bus.mem_rsp_valid  = rsp;
        bus.mem_rsp_data   = rsp ? mem_word(pend_addr) : $urandom;
        bus.mem_rsp_err    = rsp ? err_of(pend_addr) : 1'($urandom_range(1, 0));
        #1;

        hs  = exp_rv && rdy;
        pop = (queued != 0) && ird && !redir;
        if (hs) begin
            checks++;
            if (bus.mem_req_addr !== exp_req_addr) begin
                failures++;
                $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, bus.mem_req_addr, exp_req_addr);
            end
            hs_count++;
            hs_addr_q.push_back(bus.mem_req_addr);
            hs_cyc_q.push_back(cyc);
        end
        if (pop) begin
            pop_pc_q.push_back(bus.inst_pc);
            pop_snpc_q.push_back(bus.inst_snpc);
            pop_inst_q.push_back(bus.inst);
            pop_fault_q.push_back(bus.inst_fault);
            exp_pop_pc += 32'd4;
            queued--;
        end
        if (rsp) begin
            pending = 1'b0;
            if (!pend_stale && !redir) begin
                queued++;
                if (err_of(pend_addr)) halted = 1'b1;
            end
        end else if (pending) begin
            pend_wait--;
        end
        if (hs) begin
            pending    = 1'b1;
            pend_stale = 1'b0;
            pend_addr  = exp_req_addr;
            pend_wait  = $urandom_range(lat_max, lat_min);
            exp_req_addr += 32'd4;
        end
        if (redir) begin
            queued       = 0;
            halted       = 1'b0;
            exp_req_addr = redir_tgt & ~32'h3;
            exp_pop_pc   = redir_tgt & ~32'h3;
            if (pending) pend_stale = 1'b1;
        end
        redir_req = 1'b0;
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.redirect_valid = 0; bus.redirect_pc = '0; bus.mem_req_ready = 0;
        bus.mem_rsp_valid = 0; bus.mem_rsp_data = '0; bus.mem_rsp_err = 0; bus.inst_ready = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (bus.mem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL in_reset got req_valid=%b inst_valid=%b exp 0 0", bus.mem_req_valid, bus.inst_valid);
        end
        rst = 1'b0;
        #1;
        pending = 0; pend_stale = 0; halted = 0; queued = 0; pend_wait = 0;
        exp_req_addr = RPC; exp_pop_pc = RPC;
        redir_req = 0; redir_pct = 0; err_mode = 0;
        clear_logs();
    endtask

    task automatic test_reset();
        rdy_mode = 1; ird_mode = 0; lat_min = 0; lat_max = 0;
        do_reset();
        checks++;
        if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== RPC) begin
            failures++;
            $display("FAIL first_req got valid=%b addr=%h exp 1 %h", bus.mem_req_valid, bus.mem_req_addr, RPC);
        end
        repeat (7) cycle();
        do_reset();
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== RPC) begin
            failures++;
            $display("FAIL mid_reset got iv=%b rv=%b addr=%h exp 0 1 %h",
                     bus.inst_valid, bus.mem_req_valid, bus.mem_req_addr, RPC);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        rdy_mode = 1; ird_mode = 1; lat_min = 0; lat_max = 0;
        repeat (10) cycle();
        checks++;
        if (hs_addr_q.size() < 3 || pop_pc_q.size() < 1) begin
            failures++;
            $display("FAIL seq_count got hs=%0d pops=%0d exp >=3 >=1", hs_addr_q.size(), pop_pc_q.size());
        end else begin
            checks++;
            if (hs_addr_q[0] !== RPC || hs_addr_q[1] !== RPC + 32'd4 || hs_addr_q[2] !== RPC + 32'd8) begin
                failures++;
                $display("FAIL seq_addr got %h %h %h exp %h %h %h", hs_addr_q[0], hs_addr_q[1], hs_addr_q[2],
                         RPC, RPC + 32'd4, RPC + 32'd8);
            end
            checks++;
            if (hs_cyc_q[1] - hs_cyc_q[0] != 2 || hs_cyc_q[2] - hs_cyc_q[1] != 2) begin
                failures++;
                $display("FAIL seq_spacing got %0d %0d exp 2 2", hs_cyc_q[1] - hs_cyc_q[0], hs_cyc_q[2] - hs_cyc_q[1]);
            end
            checks++;
            if (first_valid_cyc != hs_cyc_q[0] + 2) begin
                failures++;
                $display("FAIL seq_latency got %0d exp %0d", first_valid_cyc, hs_cyc_q[0] + 2);
            end
            checks++;
            if (pop_pc_q[0] !== RPC || pop_snpc_q[0] !== RPC + 32'd4) begin
                failures++;
                $display("FAIL seq_pop got pc=%h snpc=%h exp %h %h", pop_pc_q[0], pop_snpc_q[0], RPC, RPC + 32'd4);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        rdy_mode = 1; ird_mode = 0; lat_min = 0; lat_max = 0;
        repeat (16) cycle();
        checks++;
        if (hs_count != D || bus.mem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_stop got hs=%0d rv=%b exp %0d 0", hs_count, bus.mem_req_valid, D);
        end
        ird_mode = 1; cycle(); ird_mode = 0;
        repeat (8) cycle();
        checks++;
        if (hs_count != D + 1 || pop_pc_q.size() != 1) begin
            failures++;
            $display("FAIL one_more got hs=%0d pops=%0d exp %0d 1", hs_count, pop_pc_q.size(), D + 1);
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        rdy_mode = 1; ird_mode = 1; lat_min = 1; lat_max = 1;
        for (int i = 0; i < 10 && hs_count == 0; i++) cycle();
        redir_req = 1; redir_tgt = 32'h8000_0102;
        cycle();
        checks++;
        if (bus.inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL redir_empty got iv=%b exp 0", bus.inst_valid);
        end
        clear_logs();
        for (int i = 0; i < 20 && pop_pc_q.size() == 0; i++) cycle();
        checks++;
        if (hs_addr_q.size() == 0 || pop_pc_q.size() == 0 ||
            hs_addr_q[0] !== 32'h8000_0100 || pop_pc_q[0] !== 32'h8000_0100) begin
            failures++;
            $display("FAIL redir_target got hs=%h pop=%h exp 80000100 80000100",
                     hs_addr_q.size() ? hs_addr_q[0] : 32'hx, pop_pc_q.size() ? pop_pc_q[0] : 32'hx);
        end
    endtask

    task automatic test_fault();
        do_reset();
        err_mode = 1; fault_addr = 32'h8000_0008;
        rdy_mode = 1; ird_mode = 1; lat_min = 0; lat_max = 0;
        repeat (16) cycle();
        checks++;
        if (hs_count != 3 || pop_pc_q.size() != 3) begin
            failures++;
            $display("FAIL fault_halt got hs=%0d pops=%0d exp 3 3", hs_count, pop_pc_q.size());
        end else begin
            checks++;
            if (pop_pc_q[2] !== 32'h8000_0008 || pop_fault_q[2] !== 1'b1 || pop_inst_q[2] !== 32'd0) begin
                failures++;
                $display("FAIL fault_entry got pc=%h f=%b inst=%h exp 80000008 1 0",
                         pop_pc_q[2], pop_fault_q[2], pop_inst_q[2]);
            end
        end
        clear_logs();
        err_mode = 0; redir_req = 1; redir_tgt = 32'h8000_0000;
        repeat (8) cycle();
        checks++;
        if (hs_addr_q.size() == 0 || pop_pc_q.size() == 0 ||
            hs_addr_q[0] !== 32'h8000_0000 || pop_pc_q[0] !== 32'h8000_0000) begin
            failures++;
            $display("FAIL fault_resume got hs=%0d pops=%0d exp fetch from 80000000", hs_addr_q.size(), pop_pc_q.size());
        end
    endtask

    task automatic test_redirect_full();
        do_reset();
        rdy_mode = 1; ird_mode = 0; lat_min = 0; lat_max = 0;
        for (int i = 0; i < 20 && !(queued == D - 1 && !pending); i++) cycle();
        ird_mode = 1; lat_min = 2; lat_max = 2;
        redir_req = 1; redir_tgt = 32'h8000_4000;
        cycle();
        lat_min = 0; lat_max = 0;
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.mem_req_valid !== 1'b0 || hs_count != D) begin
            failures++;
            $display("FAIL drop_state got iv=%b rv=%b hs=%0d exp 0 0 %0d", bus.inst_valid, bus.mem_req_valid, hs_count, D);
        end
        clear_logs();
        for (int i = 0; i < 20 && pop_pc_q.size() == 0; i++) cycle();
        checks++;
        if (hs_addr_q.size() == 0 || pop_pc_q.size() == 0 ||
            hs_addr_q[0] !== 32'h8000_4000 || pop_pc_q[0] !== 32'h8000_4000) begin
            failures++;
            $display("FAIL drop_resume got hs=%0d pops=%0d exp fetch from 80004000", hs_addr_q.size(), pop_pc_q.size());
        end
        ird_mode = 0;
        for (int i = 0; i < 30 && !(queued == D && !pending); i++) cycle();
        ird_mode = 1; redir_req = 1; redir_tgt = 32'h8000_7777;
        cycle();
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h8000_7774) begin
            failures++;
            $display("FAIL full_redir got iv=%b rv=%b addr=%h exp 0 1 80007774",
                     bus.inst_valid, bus.mem_req_valid, bus.mem_req_addr);
        end
        repeat (6) cycle();
    endtask

    task automatic test_wrap();
        do_reset();
        rdy_mode = 1; ird_mode = 1; lat_min = 0; lat_max = 0;
        redir_req = 1; redir_tgt = 32'hFFFF_FFFE;
        cycle();
        clear_logs();
        repeat (12) cycle();
        checks++;
        if (hs_addr_q.size() < 2 || pop_pc_q.size() < 1 ||
            hs_addr_q[0] !== 32'hFFFF_FFFC || hs_addr_q[1] !== 32'h0000_0000 ||
            pop_pc_q[0] !== 32'hFFFF_FFFC || pop_snpc_q[0] !== 32'h0000_0000) begin
            failures++;
            $display("FAIL wrap got hs=%0d pops=%0d exp FFFFFFFC then 00000000, snpc 0",
                     hs_addr_q.size(), pop_pc_q.size());
        end
    endtask

    task automatic test_random();
        do_reset();
        rdy_mode = 2; ird_mode = 2; lat_min = 0; lat_max = 3;
        err_mode = 2; redir_pct = 4;
        repeat (3000) cycle();
        redir_pct = 0;
        checks++;
        if (pop_pc_q.size() < 100) begin
            failures++;
            $display("FAIL random_progress got pops=%0d exp >=100", pop_pc_q.size());
        end
    endtask

    initial begin
        rdy_mode = 0; ird_mode = 0; lat_min = 0; lat_max = 0;
        err_mode = 0; redir_pct = 0; fault_addr = '0;
        redir_req = 0; redir_tgt = '0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_fault();
        test_redirect_full();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
